// File: rtl/sorted_range_merger_if.sv
// sorted_range_merger_if
//   Groups the block input, merged-range output handshake and status
//   signals of sorted_range_merger.
//   Each pair is packed {lo, hi}, with lo in the upper DATA_W bits.
//   Pair i of a block sits at pairs_in_flat[i*2*DATA_W +: 2*DATA_W].
//   Pair 0 holds the smallest lo.
//   Modports:
//     master - block producer / range consumer side
//     slave  - the merger itself
interface sorted_range_merger_if #(
  parameter int DATA_W  = 32,
  parameter int TOTAL_W = 64
);
  logic                     valid_in;
  logic [16*2*DATA_W-1:0]   pairs_in_flat;
  logic                     overflow;
  logic                     range_valid;
  logic                     range_ready;
  logic [2*DATA_W-1:0]      range_out;
  logic                     range_last;
  logic                     block_done;
  logic [TOTAL_W-1:0]       block_total;

  modport master (
    output valid_in, pairs_in_flat, range_ready,
    input  overflow, range_valid, range_out, range_last, block_done, block_total
  );

  modport slave (
    input  valid_in, pairs_in_flat, range_ready,
    output overflow, range_valid, range_out, range_last, block_done, block_total
  );
endinterface

// File: rtl/sorted_range_merger.sv
// sorted_range_merger
//   Buffers 16-pair ascending blocks of inclusive ranges {lo,hi}.
//   Scans each buffered block one element per cycle and coalesces
//   overlapping or adjacent ranges.
//   Streams the merged ranges out through a single-entry valid/ready
//   output register.
//   Reports the number of covered values of each completed block.
//   Pairs with lo > hi are padding and are ignored.
// Ports:
//   clock - single clock domain
//   reset - asynchronous, active-low
//   bus   - sorted_range_merger_if.slave, carrying:
//     valid_in / pairs_in_flat       block input, no backpressure
//     overflow                       sticky, set when a block is dropped
//     range_valid / range_ready      merged range handshake
//     range_out / range_last         merged range and end-of-block flag
//     block_done                     one-cycle pulse when a block is popped
//     block_total                    covered-value count of that block
module sorted_range_merger #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int TOTAL_W    = 64
) (
  input logic                clock,
  input logic                reset,
  sorted_range_merger_if.slave bus
);

  localparam int NELEM  = 16;
  localparam int PAIR_W = 2 * DATA_W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [DATA_W:0]   ONE_X    = (DATA_W + 1)'(1);
  localparam logic [3:0]        LAST_IDX = 4'd15;

  typedef struct packed {
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
  } pair_t;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, FLUSH} state_t;

  function automatic logic is_pad(input pair_t p);
    return p.lo > p.hi;
  endfunction

  // Adjacency test is done one bit wider so hi = all-ones does not wrap.
  function automatic logic can_merge(input pair_t c, input pair_t e);
    return {1'b0, e.lo} <= ({1'b0, c.hi} + ONE_X);
  endfunction

  // Covered-value count of a valid range; the full-span range needs DATA_W+1 bits.
  function automatic logic [TOTAL_W-1:0] range_len(input pair_t p);
    logic [DATA_W:0] len;
    len = {1'b0, p.hi} - {1'b0, p.lo} + ONE_X;
    return TOTAL_W'(len);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  pair_t              mem [FIFO_DEPTH][NELEM];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  state_t             state;
  logic [3:0]         idx;
  pair_t              cur;
  logic               cur_valid;
  logic [TOTAL_W-1:0] acc;

  logic               overflow_r;
  logic               range_valid_r;
  pair_t              range_out_r;
  logic               range_last_r;
  logic               block_done_r;
  logic [TOTAL_W-1:0] block_total_r;

  pair_t              elem;
  logic               out_free;
  logic               push;
  logic               pop;
  logic               adv;
  logic               take;
  logic               grow;
  logic               emit;
  logic               emit_last;

  assign elem     = mem[rd_ptr][idx];
  assign out_free = !range_valid_r || bus.range_ready;
  assign pop      = (state == FLUSH) && !cur_valid && out_free;
  // A full buffer still accepts a block when the head is popped the same cycle.
  assign push     = bus.valid_in && ((count != DEPTH_C) || pop);

  // Per-cycle scan decision for the current element.
  always_comb begin
    adv       = 1'b0;
    take      = 1'b0;
    grow      = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    unique case (state)
      SCAN: begin
        if (is_pad(elem)) begin
          adv = 1'b1;
        end else if (!cur_valid) begin
          take = 1'b1;
          adv  = 1'b1;
        end else if (can_merge(cur, elem)) begin
          grow = 1'b1;
          adv  = 1'b1;
        end else if (out_free) begin
          emit = 1'b1;
          take = 1'b1;
          adv  = 1'b1;
        end
      end
      FLUSH: begin
        if (cur_valid && out_free) begin
          emit      = 1'b1;
          emit_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      for (int i = 0; i < NELEM; i++) begin
        mem[wr_ptr][i] <= bus.pairs_in_flat[i*PAIR_W +: PAIR_W];
      end
    end
    if (take) begin
      cur <= elem;
    end else if (grow && (elem.hi > cur.hi)) begin
      cur.hi <= elem.hi;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      cur_valid     <= 1'b0;
      acc           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_r    <= 1'b0;
      range_valid_r <= 1'b0;
      range_out_r   <= '0;
      range_last_r  <= 1'b0;
      block_done_r  <= 1'b0;
      block_total_r <= '0;
    end else begin
      block_done_r <= 1'b0;

      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (bus.valid_in && !push) overflow_r <= 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase

      // Emitting into a register that is being accepted this cycle overrides the drain.
      if (emit) begin
        range_valid_r <= 1'b1;
        range_out_r   <= cur;
        range_last_r  <= emit_last;
        acc           <= acc + range_len(cur);
      end else if (bus.range_ready) begin
        range_valid_r <= 1'b0;
      end

      if (take) cur_valid <= 1'b1;
      if (adv)  idx <= idx + 4'd1;

      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= LOAD;
            idx       <= '0;
            cur_valid <= 1'b0;
          end
        end
        LOAD: state <= SCAN;
        SCAN: begin
          if (adv && (idx == LAST_IDX)) state <= FLUSH;
        end
        FLUSH: begin
          if (emit) begin
            cur_valid <= 1'b0;
          end else if (pop) begin
            block_done_r  <= 1'b1;
            block_total_r <= acc;
            acc           <= '0;
            idx           <= '0;
            cur_valid     <= 1'b0;
            // Remaining occupancy after this pop decides whether to start the next block.
            if ((count > CNT_ONE) || push) state <= LOAD;
            else                            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.overflow    = overflow_r;
  assign bus.range_valid = range_valid_r;
  assign bus.range_out   = range_out_r;
  assign bus.range_last  = range_last_r;
  assign bus.block_done  = block_done_r;
  assign bus.block_total = block_total_r;

endmodule

// File: tb/tb_sorted_range_merger.sv
// tb_sorted_range_merger
//   Randomized and directed blocks are fed to sorted_range_merger.
//   Expected merged ranges and block totals are queued at issue time.
//   A monitor pops and compares them on every accepted range and on
//   every block_done pulse.
//   The reference model computes the union of the valid ranges value by
//   value and reports its maximal runs.
module tb_sorted_range_merger;
  localparam int DW    = 16;
  localparam int TW    = 64;
  localparam int DEPTH = 2;
  localparam int PW    = 2 * DW;
  localparam longint unsigned VMAX = (64'd1 << DW) - 64'd1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  sorted_range_merger_if #(.DATA_W(DW), .TOTAL_W(TW)) bus ();

  sorted_range_merger #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .TOTAL_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint unsigned lo;
    longint unsigned hi;
    bit              last;
  } exp_rng_t;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int rdy_mode    = 0;

  longint unsigned blk_lo [16];
  longint unsigned blk_hi [16];
  exp_rng_t        exp_q [$];
  longint unsigned tot_q [$];

  bit              prev_stall = 1'b0;
  logic [PW-1:0]   prev_out;
  logic            prev_last;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, req);
    end
  endtask

  // Reference: walk every value between the smallest lo and the largest hi,
  // mark it covered if any valid pair contains it, and emit maximal runs.
  task automatic model_block();
    longint unsigned mn, mx, run_lo, tot;
    bit any, in_run, cov;
    longint unsigned rl [$];
    longint unsigned rh [$];
    exp_rng_t e;
    any = 0; mn = 0; mx = 0; tot = 0; in_run = 0; run_lo = 0;
    for (int i = 0; i < 16; i++) begin
      if (blk_lo[i] <= blk_hi[i]) begin
        if (!any || blk_lo[i] < mn) mn = blk_lo[i];
        if (!any || blk_hi[i] > mx) mx = blk_hi[i];
        any = 1;
      end
    end
    if (any) begin
      for (longint unsigned v = mn; v <= mx; v++) begin
        cov = 0;
        for (int i = 0; i < 16; i++)
          if (blk_lo[i] <= blk_hi[i] && v >= blk_lo[i] && v <= blk_hi[i]) cov = 1;
        if (cov && !in_run) begin run_lo = v; in_run = 1; end
        if (!cov && in_run) begin rl.push_back(run_lo); rh.push_back(v - 1); in_run = 0; end
      end
      if (in_run) begin rl.push_back(run_lo); rh.push_back(mx); end
    end
    for (int k = 0; k < rl.size(); k++) begin
      e.lo = rl[k]; e.hi = rh[k]; e.last = (k == rl.size() - 1);
      exp_q.push_back(e);
      tot += rh[k] - rl[k] + 1;
    end
    tot_q.push_back(tot);
  endtask

  function automatic logic [16*PW-1:0] pack_blk();
    logic [16*PW-1:0] f;
    for (int i = 0; i < 16; i++) f[i*PW +: PW] = {DW'(blk_lo[i]), DW'(blk_hi[i])};
    return f;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_block(input bit expected);
    if (expected) model_block();
    bus.pairs_in_flat = pack_blk();
    bus.valid_in      = 1'b1;
    tick();
    bus.valid_in      = 1'b0;
  endtask

  task automatic set_all_pad();
    for (int i = 0; i < 16; i++) begin blk_lo[i] = VMAX; blk_hi[i] = 0; end
  endtask

  task automatic set_case1();
    for (int i = 0; i < 16; i++) begin blk_lo[i] = 10 * i; blk_hi[i] = 10 * i + 2; end
  endtask

  task automatic set_case2();
    set_all_pad();
    blk_lo[0] = 1;  blk_hi[0] = 5;
    blk_lo[1] = 3;  blk_hi[1] = 8;
    blk_lo[2] = 9;  blk_hi[2] = 12;
    blk_lo[3] = 20; blk_hi[3] = 20;
    blk_lo[4] = 20; blk_hi[4] = 30;
  endtask

  task automatic set_random();
    longint unsigned base;
    base = $urandom_range(0, 40);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        blk_hi[i] = $urandom_range(0, 200);
        blk_lo[i] = blk_hi[i] + 1 + $urandom_range(0, 30);
      end else begin
        base += $urandom_range(0, 5);
        blk_lo[i] = base;
        blk_hi[i] = base + $urandom_range(0, 4);
      end
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int target;
    int c;
    target = done_cnt + n;
    c = 0;
    while (done_cnt < target && c < budget) begin tick(); c++; end
    check("blocks_done_in_time", longint'(done_cnt), longint'(target));
  endtask

  task automatic wait_valid(input int budget);
    int c;
    c = 0;
    while (!bus.range_valid && c < budget) begin tick(); c++; end
    check("range_valid_in_time", bus.range_valid, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_range_valid"}, bus.range_valid, 0);
    check({tag, "_range_out"},   bus.range_out,   0);
    check({tag, "_range_last"},  bus.range_last,  0);
    check({tag, "_block_done"},  bus.block_done,  0);
    check({tag, "_block_total"}, bus.block_total, 0);
    check({tag, "_overflow"},    bus.overflow,    0);
  endtask

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       bus.range_ready = 1'b1;
      1:       bus.range_ready = ($urandom_range(0, 3) != 0);
      default: bus.range_ready = 1'b0;
    endcase
  end

  // Monitor: compares every accepted range and every completed block.
  always @(negedge clock) begin
    exp_rng_t e;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus.range_valid, 1);
        check("hold_data", {bus.range_last, bus.range_out}, {prev_last, prev_out});
      end
      if (bus.range_valid && bus.range_ready) begin
        if (exp_q.size() == 0) begin
          check("range_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("range_lo",   bus.range_out[PW-1:DW], e.lo);
          check("range_hi",   bus.range_out[DW-1:0],  e.hi);
          check("range_last", bus.range_last,         e.last);
        end
      end
      if (bus.block_done) begin
        done_cnt++;
        if (tot_q.size() == 0) check("block_expected", tot_q.size(), 1);
        else                   check("block_total", bus.block_total, tot_q.pop_front());
      end
      prev_stall = bus.range_valid && !bus.range_ready;
      prev_out   = bus.range_out;
      prev_last  = bus.range_last;
    end
  end

  initial begin
    bus.valid_in      = 1'b0;
    bus.pairs_in_flat = '0;
    #1;
    check_outputs_zero("reset");
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Evenly spaced ranges, nothing merges.
    rdy_mode = 0;
    set_case1();
    send_block(1);
    wait_done(1, 200);

    // Overlap, adjacency, duplicates and trailing padding.
    set_case2();
    send_block(1);
    wait_done(1, 200);

    // Same block with downstream stalled while the first range is presented.
    rdy_mode = 2;
    set_case2();
    send_block(1);
    wait_valid(100);
    repeat (5) tick();
    rdy_mode = 0;
    wait_done(1, 200);

    // Three blocks two cycles apart into a depth-2 buffer: the third is dropped.
    rdy_mode = 2;
    set_random();
    send_block(1);
    tick();
    set_random();
    send_block(1);
    tick();
    check("overflow_before_drop", bus.overflow, 0);
    set_random();
    send_block(0);
    check("overflow_set", bus.overflow, 1);
    rdy_mode = 0;
    wait_done(2, 400);
    check("overflow_sticky", bus.overflow, 1);

    // Range reaching the top value, then an all-padding block.
    set_all_pad();
    blk_lo[0] = 0;    blk_hi[0] = VMAX - 1;
    blk_lo[1] = VMAX; blk_hi[1] = VMAX;
    send_block(1);
    wait_done(1, 200);
    set_all_pad();
    send_block(1);
    wait_done(1, 200);

    // Random blocks, one or two in flight, random downstream readiness.
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      int nb;
      nb = $urandom_range(1, 2);
      set_random();
      send_block(1);
      if (nb == 2) begin
        tick();
        set_random();
        send_block(1);
      end
      wait_done(nb, 800);
    end

    // Reset in the middle of a scan, then a clean block.
    rdy_mode = 2;
    repeat (4) tick();
    set_random();
    send_block(0);
    repeat (8) tick();
    reset = 1'b0;
    #1;
    check_outputs_zero("midscan_reset");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("overflow_after_reset", bus.overflow, 0);
    rdy_mode = 0;
    set_case1();
    send_block(1);
    wait_done(1, 200);

    repeat (3) tick();
    check("leftover_ranges", exp_q.size(), 0);
    check("leftover_totals", tot_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
